// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - load/store memory stage with register-result bypass and bus timeout
//
// Parameter: TIMEOUT_CYCLES (1..255) - ACCESS cycles without iMemAck before the request is abandoned.
// Optional feature: define MEM_STAGE_MISALIGN_CHK_EN to reject misaligned H/HU/W accesses.
//
// Ports:
//   iClk, iRst                 clock, synchronous active-high reset
//   iValid, iRead, iWrite      ALU output valid, load request, store request
//   iOpType                    funct3 width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   iAddr, iWrData, iRdAddr    byte address, store data, load destination register
//   iRegDv, iRegAddr, iRegData ALU register result passed through to writeback
//   oStall                     high while a memory access is outstanding
//   oMemReq/We/Addr/Be/Wdata   data-memory request, held stable through ACCESS
//   iMemAck, iMemRdata         request completion and read word
//   oWbDv, oWbAddr, oWbData    writeback pulse, register, data
//   oBusErr                    one-cycle pulse when a request times out
//   oMisalign                  one-cycle pulse on a rejected misaligned access (0 without the macro)
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  input  logic        iRead,
  input  logic        iWrite,
  input  logic [2:0]  iOpType,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  input  logic [4:0]  iRdAddr,
  input  logic        iRegDv,
  input  logic [4:0]  iRegAddr,
  input  logic [31:0] iRegData,
  output logic        oStall,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [3:0]  oMemBe,
  output logic [31:0] oMemWdata,
  input  logic        iMemAck,
  input  logic [31:0] iMemRdata,
  output logic        oWbDv,
  output logic [4:0]  oWbAddr,
  output logic [31:0] oWbData,
  output logic        oBusErr,
  output logic        oMisalign
);

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state, stateNext;
  logic [7:0]  cnt, cntNext;
  logic [2:0]  opReg, opNext;
  logic [1:0]  lowReg, lowNext;
  logic [4:0]  rdReg, rdNext;
  logic        memReqNext, memWeNext;
  logic [31:0] memAddrNext, memWdataNext;
  logic [3:0]  memBeNext;
  logic        wbDvNext, busErrNext, misalignNext;
  logic [4:0]  wbAddrNext;
  logic [31:0] wbDataNext;
  logic        misaligned;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] loadData;

  assign oStall = (state == ACCESS);

`ifdef MEM_STAGE_MISALIGN_CHK_EN
  assign misaligned = ((iOpType[1:0] == 2'b01) && iAddr[0]) ||
                      ((iOpType[1:0] == 2'b10) && (iAddr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lane extraction uses the address bits captured at request time.
  always_comb begin
    ldByte = iMemRdata[7:0];
    case (lowReg)
      2'd0: ldByte = iMemRdata[7:0];
      2'd1: ldByte = iMemRdata[15:8];
      2'd2: ldByte = iMemRdata[23:16];
      2'd3: ldByte = iMemRdata[31:24];
      default: ldByte = iMemRdata[7:0];
    endcase
    ldHalf = lowReg[1] ? iMemRdata[31:16] : iMemRdata[15:0];
    case (opReg)
      3'b000:  loadData = {{24{ldByte[7]}}, ldByte};
      3'b001:  loadData = {{16{ldHalf[15]}}, ldHalf};
      3'b100:  loadData = {24'd0, ldByte};
      3'b101:  loadData = {16'd0, ldHalf};
      default: loadData = iMemRdata;
    endcase
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    opNext       = opReg;
    lowNext      = lowReg;
    rdNext       = rdReg;
    memReqNext   = oMemReq;
    memWeNext    = oMemWe;
    memAddrNext  = oMemAddr;
    memBeNext    = oMemBe;
    memWdataNext = oMemWdata;
    wbDvNext     = 1'b0;
    wbAddrNext   = oWbAddr;
    wbDataNext   = oWbData;
    busErrNext   = 1'b0;
    misalignNext = 1'b0;
    case (state)
      IDLE: begin
        // A memory op takes priority over a same-cycle register result.
        if (iValid && (iRead || iWrite)) begin
          if (misaligned) begin
            misalignNext = 1'b1;
          end else begin
            stateNext    = ACCESS;
            cntNext      = 8'd0;
            opNext       = iOpType;
            lowNext      = iAddr[1:0];
            rdNext       = iRdAddr;
            memReqNext   = 1'b1;
            memWeNext    = iWrite;
            memAddrNext  = {iAddr[31:2], 2'b00};
            memBeNext    = 4'b1111;
            memWdataNext = 32'd0;
            if (iWrite) begin
              case (iOpType[1:0])
                2'b00: begin
                  memBeNext    = 4'b0001 << iAddr[1:0];
                  memWdataNext = {4{iWrData[7:0]}};
                end
                2'b01: begin
                  memBeNext    = iAddr[1] ? 4'b1100 : 4'b0011;
                  memWdataNext = {2{iWrData[15:0]}};
                end
                default: begin
                  memBeNext    = 4'b1111;
                  memWdataNext = iWrData;
                end
              endcase
            end
          end
        end else if (iValid && iRegDv) begin
          wbDvNext   = 1'b1;
          wbAddrNext = iRegAddr;
          wbDataNext = iRegData;
        end
      end
      ACCESS: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (iMemAck || ((cnt + 8'd1) >= TimeoutLim)) begin
          stateNext    = IDLE;
          memReqNext   = 1'b0;
          memWeNext    = 1'b0;
          memAddrNext  = 32'd0;
          memBeNext    = 4'd0;
          memWdataNext = 32'd0;
          if (iMemAck) begin
            if (!oMemWe) begin
              wbDvNext   = (rdReg != 5'd0);
              wbAddrNext = rdReg;
              wbDataNext = loadData;
            end
          end else begin
            busErrNext = 1'b1;
          end
        end else begin
          cntNext = cnt + 8'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      opReg     <= 3'd0;
      lowReg    <= 2'd0;
      rdReg     <= 5'd0;
      oMemReq   <= 1'b0;
      oMemWe    <= 1'b0;
      oMemAddr  <= 32'd0;
      oMemBe    <= 4'd0;
      oMemWdata <= 32'd0;
      oWbDv     <= 1'b0;
      oWbAddr   <= 5'd0;
      oWbData   <= 32'd0;
      oBusErr   <= 1'b0;
      oMisalign <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      opReg     <= opNext;
      lowReg    <= lowNext;
      rdReg     <= rdNext;
      oMemReq   <= memReqNext;
      oMemWe    <= memWeNext;
      oMemAddr  <= memAddrNext;
      oMemBe    <= memBeNext;
      oMemWdata <= memWdataNext;
      oWbDv     <= wbDvNext;
      oWbAddr   <= wbAddrNext;
      oWbData   <= wbDataNext;
      oBusErr   <= busErrNext;
      oMisalign <= misalignNext;
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, SHALL set the max ACCESS cycles before abort (range 1..255).
REQ-002 Ports SHALL be, in order:
 iClk  in  1  clock; single clock domain, all logic on rising edge.
 iRst  in  1  reset; synchronous, active-high.
 iValid  in  1  ALU output valid this cycle.
 iRead  in  1  load request.
 iWrite  in  1  store request.
 iOpType  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
 iAddr  in  32  byte address from ALU.
 iWrData  in  32  store data.
 iRdAddr  in  5  load destination register.
 iRegDv  in  1  ALU register result valid.
 iRegAddr  in  5  ALU result destination.
 iRegData  in  32  ALU result data.
 oStall  out  1  upstream SHALL hold its output while high.
 oMemReq  out  1  data-memory request.
 oMemWe  out  1  1 = write.
 oMemAddr  out  32  word-aligned address.
 oMemBe  out  4  byte enables.
 oMemWdata  out  32  lane-replicated store data.
 iMemAck  in  1  request complete; iMemRdata valid this cycle.
 iMemRdata  in  32  read word.
 oWbDv  out  1  writeback valid, 1-cycle pulse.
 oWbAddr  out  5  writeback register.
 oWbData  out  32  writeback data.
 oBusErr  out  1  timeout pulse.
 oMisalign  out  1  misaligned-access pulse (macro-dependent).

Function
REQ-003 FSM SHALL have states IDLE and ACCESS only.
REQ-004 IDLE, iValid&(iRead|iWrite): op registered, oMemReq=1 next cycle, go ACCESS; iRead&iWrite together SHALL be treated as store.
REQ-005 IDLE, iValid&iRegDv with no mem op: oWbDv=1, oWbAddr=iRegAddr, oWbData=iRegData next cycle (1-cycle latency).
REQ-006 Mem op and iRegDv in same cycle: mem op SHALL win; register result dropped.
REQ-007 oStall SHALL equal (state==ACCESS), combinational from state.
REQ-008 All inputs except iMemAck/iMemRdata SHALL be ignored in ACCESS.
REQ-009 oMemReq, oMemWe, oMemAddr, oMemBe, oMemWdata SHALL be stable throughout ACCESS.
REQ-010 oMemAddr = {addr[31:2],2'b00}.
REQ-011 Store B: Be=0001<<addr[1:0], Wdata=byte x4; H: Be=addr[1]?1100:0011, Wdata=half x2; W: Be=1111.
REQ-012 Load: oMemWe=0, oMemBe=1111.
REQ-013 iMemAck in ACCESS: oMemReq drops same edge, return IDLE; load SHALL give oWbDv next cycle, oWbAddr=iRdAddr.
REQ-014 Load data: lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-015 Load with iRdAddr=0: oWbDv SHALL stay 0.
REQ-016 Store completion SHALL NOT produce oWbDv.
REQ-017 8-bit counter cleared on ACCESS entry, +1 per cycle without ack; at TIMEOUT_CYCLES: drop oMemReq, oBusErr=1 one cycle, IDLE, no writeback.
REQ-018 Ack and timeout same cycle: ack SHALL win.
REQ-019 iMemAck outside ACCESS SHALL be ignored.

Reset
REQ-020 iRst=1: state IDLE, counter 0, all outputs 0 at that edge, including mid-ACCESS (request abandoned, no writeback, no oBusErr).
REQ-021 First op SHALL be accepted on the first edge with iRst=0.

Configuration
REQ-022 Macro MEM_STAGE_MISALIGN_CHK_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL NOT issue a request; oMisalign=1 one cycle, stay IDLE, no writeback.
REQ-023 Macro undefined: oMisalign tied 0; low address bits ignored for lane selection of the misaligned width (H uses addr[1], W uses none).

Verification
REQ-024 LB addr 0x103, rdata 0x80FFFFFF, ack after 3 cycles -> oMemAddr 0x100, oWbData 0xFFFFFF80, oStall high 3 cycles.
REQ-025 SH addr 0x202, wdata 0x1234ABCD -> oMemBe 1100, oMemWdata 0xABCDABCD, oMemWe 1, no oWbDv.
REQ-026 LHU addr 0x0, rdata 0x0000F00D -> oWbData 0x0000F00D; LH same -> 0xFFFFF00D.
REQ-027 TIMEOUT_CYCLES=4, no ack -> oBusErr pulse after 4 ACCESS cycles, oMemReq 0, IDLE.
REQ-028 iRst during ACCESS then ack next cycle -> no oWbDv, all outputs 0.
REQ-029 MEM_STAGE_MISALIGN_CHK_EN, LW addr 0x6 -> oMisalign pulse, oMemReq never 1.
